// File: rtl/slot_spin_ctrl.sv
// ---------------------------------------------------------------------------
// slot_spin_ctrl
//
// Game sequencer for the slot machine. It takes debounced start/stop button
// levels and runs one game:
//   1. It starts all three reels.
//   2. It stops the reels one at a time, lowest index first. A reel stops on
//      an accepted stop press, or automatically after a fixed time.
//   3. It latches the stopped symbols and scores them (pair / jackpot).
//   4. It holds the result for a fixed time.
//   5. It keeps a saturating credit balance.
//
// Parameters
//   MIN_SPIN_CYCLES   cycles a reel stage must run before a stop press counts
//   AUTO_STOP_CYCLES  stage length when no press is accepted
//                     (must exceed MIN_SPIN_CYCLES)
//   RESULT_CYCLES     cycles the result is shown
//   CREDIT_INIT       balance after reset
//   CREDIT_MAX        saturation ceiling (<= 127)
//   PAIR_PAY          credits awarded for a pair
//   JACKPOT_PAY       credits awarded for a jackpot
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start_btn     in   debounced start level, 1 = pressed
//   stop_btn      in   debounced stop level, 1 = pressed
//   reel0_sym     in   live symbol (0-9) of reel 0
//   reel1_sym     in   live symbol (0-9) of reel 1
//   reel2_sym     in   live symbol (0-9) of reel 2
//   reel_run      out  bit k = 1 lets reel k advance
//   busy          out  high in every state except IDLE
//   result_valid  out  high only while the result is shown
//   win_level     out  0 none, 1 pair, 2 jackpot; held while shown
//   credits       out  current balance
// ---------------------------------------------------------------------------
module slot_spin_ctrl #(
  parameter int unsigned MIN_SPIN_CYCLES  = 25_000_000,
  parameter int unsigned AUTO_STOP_CYCLES = 150_000_000,
  parameter int unsigned RESULT_CYCLES    = 100_000_000,
  parameter int unsigned CREDIT_INIT      = 10,
  parameter int unsigned CREDIT_MAX       = 99,
  parameter int unsigned PAIR_PAY         = 2,
  parameter int unsigned JACKPOT_PAY      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic [3:0] reel0_sym,
  input  logic [3:0] reel1_sym,
  input  logic [3:0] reel2_sym,
  output logic [2:0] reel_run,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] win_level,
  output logic [6:0] credits
);

  // -------------------------------------------------------------------------
  // State encoding and constants
  // -------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPIN3 = 3'd1;  // three reels running
  localparam logic [2:0] S_SPIN2 = 3'd2;  // two reels running
  localparam logic [2:0] S_SPIN1 = 3'd3;  // one reel running
  localparam logic [2:0] S_EVAL  = 3'd4;
  localparam logic [2:0] S_SHOW  = 3'd5;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_PAIR = 2'd1;
  localparam logic [1:0] WIN_JACK = 2'd2;

  localparam logic [27:0] LP_MIN_SPIN  = 28'(MIN_SPIN_CYCLES);
  localparam logic [27:0] LP_AUTO_LAST = 28'(AUTO_STOP_CYCLES - 1);
  localparam logic [27:0] LP_SHOW_LAST = 28'(RESULT_CYCLES - 1);
  localparam logic [6:0]  LP_CRED_INIT = 7'(CREDIT_INIT);
  localparam logic [7:0]  LP_CRED_MAX  = 8'(CREDIT_MAX);
  localparam logic [7:0]  LP_PAIR_PAY  = 8'(PAIR_PAY);
  localparam logic [7:0]  LP_JACK_PAY  = 8'(JACKPOT_PAY);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [27:0] r_timer;
  logic        r_start_q;
  logic        r_stop_q;
  logic [2:0]  r_reel_run;
  logic        r_busy;
  logic        r_result_valid;
  logic [1:0]  r_win_level;
  logic [6:0]  r_credits;
  logic [3:0]  r_sym_lat0;
  logic [3:0]  r_sym_lat1;
  logic [3:0]  r_sym_lat2;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic        w_start_ev;
  logic        w_stop_ev;
  logic        w_in_spin;
  logic        w_counting;
  logic        w_spin_go;
  logic        w_stage_stop;
  logic        w_show_done;
  logic [2:0]  w_stop_mask;
  logic [2:0]  w_state_nxt;
  logic [27:0] w_timer_nxt;
  logic        w_jackpot;
  logic        w_pair;
  logic [1:0]  w_win;
  logic [7:0]  w_pay;
  logic [7:0]  w_sum;
  logic [6:0]  w_credits_eval;

  // -------------------------------------------------------------------------
  // Button edge detection
  // -------------------------------------------------------------------------
  // The delayed copies reset to 1. A button already held while reset is
  // released therefore produces no event until it is released and pressed
  // again.
  assign w_start_ev = start_btn & ~r_start_q;
  assign w_stop_ev  = stop_btn  & ~r_stop_q;

  // -------------------------------------------------------------------------
  // Stage qualifiers
  // -------------------------------------------------------------------------
  assign w_in_spin  = (r_state == S_SPIN3) || (r_state == S_SPIN2) ||
                      (r_state == S_SPIN1);
  assign w_counting = w_in_spin || (r_state == S_SHOW);

  assign w_spin_go  = (r_state == S_IDLE) && w_start_ev && (r_credits != '0);

  // An early stop press is not remembered; only the cycle of the press counts.
  // The press and the auto-stop are combined with OR. If both occur in the
  // same cycle, there is still only one stage transition, so one reel stops.
  assign w_stage_stop = w_in_spin &&
                        ((w_stop_ev && (r_timer >= LP_MIN_SPIN)) ||
                         (r_timer == LP_AUTO_LAST));

  assign w_show_done = (r_state == S_SHOW) && (r_timer == LP_SHOW_LAST);

  // Each stage stops the lowest-numbered reel that is still running.
  always_comb begin
    w_stop_mask = 3'b000;
    case (r_state)
      S_SPIN3: w_stop_mask = 3'b001;
      S_SPIN2: w_stop_mask = 3'b010;
      S_SPIN1: w_stop_mask = 3'b100;
      default: w_stop_mask = 3'b000;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_spin_go)    w_state_nxt = S_SPIN3;
      S_SPIN3: if (w_stage_stop) w_state_nxt = S_SPIN2;
      S_SPIN2: if (w_stage_stop) w_state_nxt = S_SPIN1;
      S_SPIN1: if (w_stage_stop) w_state_nxt = S_EVAL;
      S_EVAL:                    w_state_nxt = S_SHOW;
      S_SHOW:  if (w_show_done)  w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage timer
  // -------------------------------------------------------------------------
  // The timer restarts from zero on every state change. It runs only in the
  // spin and show states; in IDLE and EVAL it holds at zero.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if (w_counting) begin
      w_timer_nxt = r_timer + 28'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Scoring
  // -------------------------------------------------------------------------
  // A pair needs adjacent reels to match (0 with 1, or 1 with 2). Reels 0 and
  // 2 matching on their own do not score.
  assign w_jackpot = (r_sym_lat0 == r_sym_lat1) && (r_sym_lat1 == r_sym_lat2);
  assign w_pair    = (r_sym_lat0 == r_sym_lat1) || (r_sym_lat1 == r_sym_lat2);

  always_comb begin
    w_win = WIN_NONE;
    w_pay = 8'd0;
    if (w_jackpot) begin
      w_win = WIN_JACK;
      w_pay = LP_JACK_PAY;
    end else if (w_pair) begin
      w_win = WIN_PAIR;
      w_pay = LP_PAIR_PAY;
    end
  end

  // The sum is formed 8 bits wide so the ceiling compare sees a carry out of
  // the 7-bit balance.
  assign w_sum = {1'b0, r_credits} + w_pay;

  always_comb begin
    w_credits_eval = w_sum[6:0];
    if (w_sum > LP_CRED_MAX) begin
      w_credits_eval = LP_CRED_MAX[6:0];
    end
  end

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  // busy and result_valid are registered from the next state, so they change
  // in the same cycle as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_start_q      <= 1'b1;
      r_stop_q       <= 1'b1;
      r_reel_run     <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_win_level    <= WIN_NONE;
      r_credits      <= LP_CRED_INIT;
      r_sym_lat0     <= '0;
      r_sym_lat1     <= '0;
      r_sym_lat2     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_start_q      <= start_btn;
      r_stop_q       <= stop_btn;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_result_valid <= (w_state_nxt == S_SHOW);

      // Start a game: run all reels and spend one credit.
      if (w_spin_go) begin
        r_reel_run <= 3'b111;
        r_credits  <= r_credits - 7'd1;
      end

      // Stop one reel and latch the symbol it shows in this cycle.
      if (w_stage_stop) begin
        r_reel_run <= r_reel_run & ~w_stop_mask;
        if (w_stop_mask[0]) r_sym_lat0 <= reel0_sym;
        if (w_stop_mask[1]) r_sym_lat1 <= reel1_sym;
        if (w_stop_mask[2]) r_sym_lat2 <= reel2_sym;
      end

      // Score the latched symbols and pay out.
      if (r_state == S_EVAL) begin
        r_win_level <= w_win;
        r_credits   <= w_credits_eval;
      end

      // Clear the result when returning to IDLE.
      if (w_show_done) begin
        r_win_level <= WIN_NONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign reel_run     = r_reel_run;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign win_level    = r_win_level;
  assign credits      = r_credits;

endmodule

// File: doc/slot_spin_ctrl.md
# slot_spin_ctrl

Game sequencer for the slot machine: consumes the debounced, active-high start/stop button levels and sequences the three reel counters. It starts all reels, stops them one at a time (on a stop press or automatically), latches the stopped symbols, scores the result, and maintains the credit balance. It sits between the button debouncers and the reel/display logic.

## Interface
- MIN_SPIN_CYCLES, 25_000_000: cycles a reel stage must run before a stop press is accepted.
- AUTO_STOP_CYCLES, 150_000_000: cycles after which the next reel stops without a press. Must be greater than MIN_SPIN_CYCLES.
- RESULT_CYCLES, 100_000_000: cycles the result is held in SHOW.
- CREDIT_INIT, 10: credit balance after reset.
- CREDIT_MAX, 99: saturation ceiling for credits. Must be 127 or less.
- PAIR_PAY, 2 / JACKPOT_PAY, 10: credits awarded per win class.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_btn  in  1  debounced start level, 1 = pressed.
- stop_btn  in  1  debounced stop level, 1 = pressed.
- reel0_sym, reel1_sym, reel2_sym  in  4 each  live symbol (0–9) from each reel counter.
- reel_run  out  3  bit k = 1 means reel k advances.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  high only in SHOW.
- win_level  out  2  0 = none, 1 = pair, 2 = jackpot. Held through SHOW.
- credits  out  7  current balance.

## Operation
- Edge detection:
  - Registered copies start_q and stop_q.
  - An event is `btn & ~btn_q`.
  - start_q and stop_q reset to 1, so a button held through reset produces no event.
- States: IDLE, SPIN3, SPIN2, SPIN1, EVAL, SHOW.
- timer: 28-bit counter, cleared on every state entry, incrementing each cycle while in SPIN3, SPIN2, SPIN1 or SHOW.
- IDLE:
  - A start event with credits > 0 moves to SPIN3, sets reel_run = 3'b111 and decrements credits by 1.
  - A start event with credits == 0 is ignored.
- SPIN3 → SPIN2 → SPIN1 → EVAL. Each transition stops the lowest-numbered reel still running.
  - A stage's stop condition is either:
    - a stop event while timer ≥ MIN_SPIN_CYCLES, or
    - timer == AUTO_STOP_CYCLES−1.
  - On that transition, clear reel_run[k] and latch reelk_sym into sym_lat[k] in the same cycle.
  - A stop press and the auto-stop firing in the same cycle stop exactly one reel.
  - A stop event while timer < MIN_SPIN_CYCLES is discarded, not queued.
- EVAL (one cycle):
  - Jackpot if sym_lat0 == sym_lat1 == sym_lat2.
  - Otherwise pair if sym_lat0 == sym_lat1 or sym_lat1 == sym_lat2.
  - Otherwise no win.
  - credits ← min(credits + pay, CREDIT_MAX), computed 8 bits wide before the compare.
  - win_level is registered. Go to SHOW.
- SHOW:
  - result_valid = 1.
  - Return to IDLE when timer == RESULT_CYCLES−1.
  - All button events are ignored.
  - win_level is cleared to 0 on entry to IDLE.
- Start events in SPIN/EVAL/SHOW are ignored. Stop events in IDLE/EVAL/SHOW are ignored.
- Reset, including mid-spin:
  - state = IDLE, reel_run = 0, credits = CREDIT_INIT, win_level = 0.
  - result_valid = 0, busy = 0, timer = 0, sym_lat = 0.
  - A credit spent on an interrupted spin is not refunded.

## Timing
- All outputs are registered.
- Start event seen at cycle N (start_btn = 1, start_q = 0): at N+1, reel_run = 111, busy = 1, credits decremented.
- Stop accepted at cycle N: at N+1, reel_run bit cleared. The latched symbol is reelk_sym sampled at cycle N.
- Auto-stop: a stage lasts exactly AUTO_STOP_CYCLES cycles from entry when no press arrives.
- SPIN1 → EVAL at N: EVAL occupies N+1. At N+2, credits and win_level update and result_valid = 1.
- SHOW lasts exactly RESULT_CYCLES cycles. busy falls the cycle after.
- A one-cycle start or stop pulse suffices. A button held high produces a single event.

## Test plan
- Small parameters (MIN = 4, AUTO = 16, RESULT = 8, CREDIT_INIT = 1).
  - Stimulus: press start, hold it, let all reels auto-stop.
  - Required: credits 1→0; reel_run 111→110→100→000 at 16-cycle spacing; SHOW lasts 8 cycles; a second start with 0 credits is ignored.
- Jackpot with saturation.
  - Stimulus: all syms = 7 while stopping; CREDIT_INIT = 95.
  - Required: after EVAL, win_level = 2 and credits = min(94 + 10, 99) = 99.
- Pair and miss.
  - Stimulus: stop with syms (3, 3, 5), then (1, 2, 1).
  - Required: first spin win_level = 1 with +2 credits; second spin win_level = 0 with no credit change.
- Early stop.
  - Stimulus: stop pulse at timer = 2 (< MIN), then at timer = 6.
  - Required: only the second stops reel0; no queued extra stop.
- Simultaneous events.
  - Stimulus: stop event exactly at timer == AUTO−1.
  - Required: exactly one reel stops. A start pulse during SPIN or SHOW has no effect.
- Reset mid-spin.
  - Stimulus: assert rst_n = 0 asynchronously in SPIN2.
  - Required: outputs go to reset values immediately. Holding start through reset release yields no spin until it is released and pressed again.
